// File: rtl/io_bus_responder.sv
// Device end of the CPU IO bus: LED, debounced switch entry, scanned 8-digit
// 7-segment display and a free-running cycle counter.
module io_bus_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SCAN_CYCLES     = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

    typedef enum logic [5:0] {
        REG_LED      = 6'h00,
        REG_SW_READY = 6'h01,
        REG_SW_DATA  = 6'h02,
        REG_SEG_DATA = 6'h03,
        REG_CYCLE    = 6'h04
    } reg_e;

    logic [5:0] word;
    logic       unused_addr_bits;
    logic       wr_led, wr_seg, rd_sw_data;

    assign word             = io_addr[7:2];
    assign unused_addr_bits = ^io_addr[1:0];
    assign wr_led           = io_we && (word == REG_LED);
    assign wr_seg           = io_we && (word == REG_SEG_DATA);
    assign rd_sw_data       = io_rd && (word == REG_SW_DATA);

    logic            btn_s1_q, btn_s_q;
    logic [15:0]     sw_s1_q, sw_s_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [15:0]     sw_data_q, sw_data_d;
    logic            ready_q, ready_d;
    logic [15:0]     led_q, led_d;
    logic [31:0]     seg_data_q, seg_data_d;
    logic [31:0]     cycle_q, cycle_d;
    logic [SC_W-1:0] scnt_q, scnt_d;
    logic [2:0]      digit_q, digit_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q <= 1'b0;
            btn_s_q  <= 1'b0;
            sw_s1_q  <= '0;
            sw_s_q   <= '0;
        end else begin
            btn_s1_q <= btn;
            btn_s_q  <= btn_s1_q;
            sw_s1_q  <= sw;
            sw_s_q   <= sw_s1_q;
        end
    end

    // press is the registered rising edge of the next stable level, so the
    // entry register latches one edge after stable rises.
    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        if (btn_s_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = btn_s_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        press_d = stable_d & ~stable_q;
    end

    always_comb begin
        sw_data_d = sw_data_q;
        ready_d   = ready_q;
        if (press_q) begin
            sw_data_d = sw_s_q;
            ready_d   = 1'b1;
        end else if (rd_sw_data) begin
            ready_d   = 1'b0;
        end
    end

    always_comb begin
        led_d      = wr_led ? io_dout[15:0] : led_q;
        seg_data_d = wr_seg ? io_dout : seg_data_q;
        cycle_d    = cycle_q + 32'd1;
    end

    always_comb begin
        scnt_d  = scnt_q + 1'b1;
        digit_d = digit_q;
        if (scnt_q == SC_LAST) begin
            scnt_d  = '0;
            digit_d = digit_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q   <= '0;
            stable_q   <= 1'b0;
            press_q    <= 1'b0;
            sw_data_q  <= '0;
            ready_q    <= 1'b0;
            led_q      <= '0;
            seg_data_q <= '0;
            cycle_q    <= '0;
            scnt_q     <= '0;
            digit_q    <= '0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            stable_q   <= stable_d;
            press_q    <= press_d;
            sw_data_q  <= sw_data_d;
            ready_q    <= ready_d;
            led_q      <= led_d;
            seg_data_q <= seg_data_d;
            cycle_q    <= cycle_d;
            scnt_q     <= scnt_d;
            digit_q    <= digit_d;
        end
    end

    always_comb begin
        io_din = '0;
        case (word)
            REG_SW_READY: io_din = {31'b0, ready_q};
            REG_SW_DATA:  io_din = {16'b0, sw_data_q};
            REG_CYCLE:    io_din = cycle_q;
            default:      io_din = '0;
        endcase
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [3:0] nibble;

    assign nibble = seg_data_q[{digit_q, 2'b00} +: 4];
    assign led    = led_q;
    assign an     = ~(8'b1 << digit_q);
    assign seg    = hex7(nibble);

endmodule

// File: tb/tb_io_bus_responder.sv
// Scoreboard bench for io_bus_responder with short debounce and scan periods.
module tb_io_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we, io_rd;
    logic [31:0] io_din;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] got;
    logic [31:0] ra, rb;

    io_bus_responder #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout),
        .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .sw(sw), .btn(btn),
        .led(led), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr = a; io_dout = d; io_we = 1'b1;
        @(negedge clk);
        io_we = 1'b0; io_addr = 8'hFC;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        io_addr = a; io_rd = 1'b1;
        #1 d = io_din;
        @(negedge clk);
        io_rd = 1'b0; io_addr = 8'hFC;
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] d);
        io_addr = a;
        #1 d = io_din;
    endtask

    task automatic enter(input logic [15:0] v);
        sw = v;
        @(negedge clk); btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task test_reset;
        #2;
        sb.push_back('{name:"rst_led", exp:32'h0});
        got = {16'h0, led};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"rst_an", exp:32'hFE});
        got = {24'h0, an};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"rst_seg", exp:32'h40});
        got = {25'h0, seg};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"rst_cycle", exp:32'h0});
        peek(8'h10, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"rst_ready", exp:32'h0});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task test_regs;
        sb.push_back('{name:"led_write", exp:32'h0000ABCD});
        bus_write(8'h00, 32'h1234ABCD);
        got = {16'h0, led};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"led_ro_write_ignored", exp:32'h0000ABCD});
        bus_write(8'h04, 32'hFFFFFFFF);
        got = {16'h0, led};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"sw_data_write_ignored", exp:32'h0});
        bus_write(8'h08, 32'h00001234);
        bus_read(8'h08, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"seg_next_cycle", exp:32'h0E});
        bus_write(8'h0C, 32'hFFFFFFFF);
        got = {25'h0, seg};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        bus_write(8'h0C, 32'h76543210);
        for (int i = 0; i < 40 && an !== 8'hFE; i++) @(negedge clk);
        sb.push_back('{name:"digit0_seg", exp:32'h40});
        got = (an === 8'hFE) ? {25'h0, seg} : 32'hDEAD;
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        for (int i = 0; i < 40 && an !== 8'hFD; i++) @(negedge clk);
        sb.push_back('{name:"digit1_seg", exp:32'h79});
        got = (an === 8'hFD) ? {25'h0, seg} : 32'hDEAD;
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"read_seg_data_wo", exp:32'h0});
        bus_read(8'h0C, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"read_led_wo", exp:32'h0});
        bus_read(8'h00, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"read_unmapped", exp:32'h0});
        bus_read(8'h14, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
    endtask

    task test_switch_entry;
        sw = 16'hBEEF;
        @(negedge clk); btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sb.push_back('{name:$sformatf("ready_edge%0d", k), exp:(k >= 7) ? 32'h1 : 32'h0});
            peek(8'h04, got);
            e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        end
        sb.push_back('{name:"sw_data_beef", exp:32'h0000BEEF});
        bus_read(8'h08, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"ready_cleared", exp:32'h0});
        bus_read(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        btn = 1'b0;
        repeat (12) @(negedge clk);
        sb.push_back('{name:"release_no_press", exp:32'h0});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
    endtask

    task test_glitch;
        @(negedge clk); btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        sb.push_back('{name:"glitch_rejected", exp:32'h0});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sw = 16'h0F0F;
        btn = 1'b1;
        sb.push_back('{name:"held_press", exp:32'h1});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            peek(8'h04, got);
            if (got[0] === 1'b1) break;
        end
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"held_data", exp:32'h00000F0F});
        bus_read(8'h08, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        repeat (20) @(negedge clk);
        sb.push_back('{name:"no_second_press", exp:32'h0});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task test_collision;
        enter(16'h0001);
        sb.push_back('{name:"pre_collide_ready", exp:32'h1});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sw = 16'h0002;
        @(negedge clk); btn = 1'b1;
        repeat (6) @(negedge clk);
        io_addr = 8'h08; io_rd = 1'b1;
        sb.push_back('{name:"collide_read_old", exp:32'h1});
        #1 got = io_din;
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        @(negedge clk);
        io_rd = 1'b0;
        sb.push_back('{name:"collide_ready_kept", exp:32'h1});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"collide_new_data", exp:32'h2});
        bus_read(8'h08, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task test_scan_counter;
        logic [7:0] prev;
        logic [7:0] walk;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            prev = an;
            @(negedge clk);
            if (prev === 8'h7F && an === 8'hFE) found = 1'b1;
        end
        sb.push_back('{name:"scan_wrap_7F_FE", exp:32'h1});
        got = {31'h0, found};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        for (int k = 1; k < 27; k++) begin
            @(negedge clk);
            walk = 8'h01 << ((k / 3) % 8);
            sb.push_back('{name:$sformatf("scan_an_%0d", k), exp:{24'h0, ~walk}});
            got = {24'h0, an};
            e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        end
        bus_read(8'h10, ra);
        repeat (8) @(negedge clk);
        bus_read(8'h10, rb);
        sb.push_back('{name:"cycle_delta", exp:32'd10});
        got = rb - ra;
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        @(negedge clk);
        force dut.cycle_q = 32'hFFFFFFFF;
        sb.push_back('{name:"cycle_forced", exp:32'hFFFFFFFF});
        peek(8'h10, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        release dut.cycle_q;
        @(negedge clk);
        sb.push_back('{name:"cycle_wrap", exp:32'h0});
        peek(8'h10, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
    endtask

    task test_reset_midrun;
        enter(16'h5A5A);
        bus_write(8'h00, 32'h0000FFFF);
        sb.push_back('{name:"mid_pre_ready", exp:32'h1});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"mid_pre_led", exp:32'h0000FFFF});
        got = {16'h0, led};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb.push_back('{name:"mid_led", exp:32'h0});
        got = {16'h0, led};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"mid_an", exp:32'hFE});
        got = {24'h0, an};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"mid_seg", exp:32'h40});
        got = {25'h0, seg};
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"mid_ready", exp:32'h0});
        peek(8'h04, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        sb.push_back('{name:"mid_sw_data", exp:32'h0});
        peek(8'h08, got);
        e = sb.pop_front(); n_total++; if (got !== e.exp) $display("FAIL %s: actual %h required %h", e.name, got, e.exp); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; io_addr = 8'hFC; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
        sw = '0; btn = 1'b0;
        test_reset;
        test_regs;
        test_switch_entry;
        test_glitch;
        test_collision;
        test_scan_counter;
        test_reset_midrun;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
